// File: rtl/read_channel_distributor_if.sv
// read_channel_distributor_if: SRAM read-beat input and per-port delivery bus for the read channel distributor.
interface read_channel_distributor_if #(
    parameter int num_of_ports       = 16,
    parameter int arbiter_data_width = 256
);
    logic                          rd_valid;
    logic                          rd_ready;
    logic [3:0]                    rd_port;
    logic [arbiter_data_width-1:0] rd_data;
    logic [num_of_ports-1:0]       port_valid;
    logic [num_of_ports-1:0]       port_ready;
    logic [arbiter_data_width-1:0] port_data;
    logic [3:0]                    delivered;
    logic                          bad_port;
    logic                          timeout_drop;

    modport master (
        input  rd_valid, rd_port, rd_data, port_ready,
        output rd_ready, port_valid, port_data, delivered, bad_port, timeout_drop
    );

    modport slave (
        output rd_valid, rd_port, rd_data, port_ready,
        input  rd_ready, port_valid, port_data, delivered, bad_port, timeout_drop
    );
endinterface

// File: rtl/read_channel_distributor.sv
// read_channel_distributor: routes port-tagged SRAM read beats through a small FIFO to one of N client ports.
// Optional READ_DIST_TIMEOUT_EN drops a beat whose port stalls for timeout_cycles HOLD cycles.
module read_channel_distributor #(
    parameter int num_of_ports       = 16,
    parameter int arbiter_data_width = 256,
    parameter int fifo_depth         = 2,
    parameter int timeout_cycles     = 64
) (
    input logic clk,
    input logic rst,
    read_channel_distributor_if.master bus
);
    localparam int aw = $clog2(fifo_depth);

    if (num_of_ports > 16 || fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0 || timeout_cycles < 2) begin : g_bad_cfg
        $error("read_channel_distributor: unsupported parameter set");
    end

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;

    logic [3:0]                    port_mem [fifo_depth];
    logic [arbiter_data_width-1:0] data_mem [fifo_depth];
    logic [aw-1:0]                 wr_ptr, rd_ptr;
    logic [aw:0]                   count;
    logic [3:0]                    out_port;
    logic [arbiter_data_width-1:0] out_data;
    logic empty, push, pop, load, head_ok, hs, done, to;

    assign empty       = count == '0;
    assign bus.rd_ready = count != (aw + 1)'(fifo_depth);
    assign push        = bus.rd_valid && bus.rd_ready;
    assign head_ok     = int'(port_mem[rd_ptr]) < num_of_ports;
    assign hs          = state == HOLD && |(bus.port_valid & bus.port_ready);
    assign done        = hs || to;
    // A bad head behind a completing beat waits for IDLE so the drop pulse stays in IDLE
    assign pop         = !empty && (state == IDLE || (done && head_ok));
    assign load        = pop && head_ok;
    assign bus.bad_port   = pop && !head_ok;
    assign bus.port_valid = state == HOLD ? num_of_ports'(1) << out_port : '0;
    assign bus.port_data  = state == HOLD ? out_data : '0;

`ifdef READ_DIST_TIMEOUT_EN
    localparam int tw = $clog2(timeout_cycles) > 8 ? $clog2(timeout_cycles) : 8;
    logic [tw-1:0] stall;
    assign to = state == HOLD && !hs && stall == tw'(timeout_cycles - 1);
    assign bus.timeout_drop = to;
    always_ff @(posedge clk) begin
        if (rst || load || hs) stall <= '0;
        else if (state == HOLD) stall <= stall + 1'b1;
    end
`else
    assign to = 1'b0;
    assign bus.timeout_drop = 1'b0;
`endif

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        state_n = load ? HOLD : done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            port_mem[wr_ptr] <= bus.rd_port;
            data_mem[wr_ptr] <= bus.rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            out_port      <= '0;
            out_data      <= '0;
            bus.delivered <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (aw + 1)'(push) - (aw + 1)'(pop);
            if (load) begin
                out_port <= port_mem[rd_ptr];
                out_data <= data_mem[rd_ptr];
            end
            if (hs) bus.delivered <= out_port;
        end
    end
endmodule

// File: tb/tb_read_channel_distributor.sv
// tb_read_channel_distributor: directed tests for the read channel distributor (16-port and 8-port instances).
module tb_read_channel_distributor;
    localparam int DW = 256;
    localparam logic [DW-1:0] A5 = {32{8'hA5}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    read_channel_distributor_if #(.num_of_ports(16), .arbiter_data_width(DW)) b16 ();
    read_channel_distributor_if #(.num_of_ports(8), .arbiter_data_width(DW)) b8 ();

    read_channel_distributor #(.num_of_ports(16), .arbiter_data_width(DW), .fifo_depth(2), .timeout_cycles(64))
        dut (.clk(clk), .rst(rst), .bus(b16));
    read_channel_distributor #(.num_of_ports(8), .arbiter_data_width(DW), .fifo_depth(2), .timeout_cycles(64))
        dut8 (.clk(clk), .rst(rst), .bus(b8));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b16.rd_valid = 1'b0; b16.rd_port = '0; b16.rd_data = '0; b16.port_ready = '1;
        b8.rd_valid = 1'b0;  b8.rd_port = '0;  b8.rd_data = '0;  b8.port_ready = '1;
        cyc(); cyc();
        rst = 1'b0;
        mid();
        checks++; if (b16.port_valid !== 16'h0) begin errors++; $display("FAIL reset_pv: got %h want 0000", b16.port_valid); end
        checks++; if (b16.port_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", b16.port_data); end
        checks++; if (b16.delivered !== 4'd0) begin errors++; $display("FAIL reset_delivered: got %0d want 0", b16.delivered); end
        checks++; if (b16.rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready: got %b want 1", b16.rd_ready); end
        checks++; if (b16.bad_port !== 1'b0 || b16.timeout_drop !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", b16.bad_port, b16.timeout_drop); end
    endtask

    task automatic test_single();
        cyc();
        b16.rd_valid = 1'b1; b16.rd_port = 4'd3; b16.rd_data = A5;
        cyc();
        b16.rd_valid = 1'b0;
        mid();
        checks++; if (b16.port_valid !== 16'h0) begin errors++; $display("FAIL single_early: got %h want 0000", b16.port_valid); end
        cyc(); mid();
        checks++; if (b16.port_valid !== 16'h0008) begin errors++; $display("FAIL single_pv: got %h want 0008", b16.port_valid); end
        checks++; if (b16.port_data !== A5) begin errors++; $display("FAIL single_data: got %h want %h", b16.port_data, A5); end
        cyc(); mid();
        checks++; if (b16.delivered !== 4'd3) begin errors++; $display("FAIL single_delivered: got %0d want 3", b16.delivered); end
        checks++; if (b16.port_valid !== 16'h0) begin errors++; $display("FAIL single_idle: got %h want 0000", b16.port_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [15:0] exp_pv;
            exp_pv = (i >= 2 && i <= 4) ? 16'(1 << (i - 2)) : 16'h0;
            cyc();
            b16.rd_valid = i < 3; b16.rd_port = 4'(i); b16.rd_data = DW'(i + 'h100);
            mid();
            checks++; if (b16.rd_ready !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready[%0d]: got %b want 1", i, b16.rd_ready); end
            checks++; if (b16.port_valid !== exp_pv) begin errors++; $display("FAIL b2b_pv[%0d]: got %h want %h", i, b16.port_valid, exp_pv); end
            if (i >= 2 && i <= 4) begin
                checks++; if (b16.port_data !== DW'(i - 2 + 'h100)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, b16.port_data, DW'(i - 2 + 'h100)); end
            end
        end
        b16.rd_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            logic exp_rr;
            logic [15:0] exp_pv;
            logic [DW-1:0] exp_d;
            exp_rr = !(i >= 3 && i <= 6);
            exp_pv = (i >= 2 && i <= 8) ? 16'h0020 : 16'h0;
            exp_d  = i <= 6 ? DW'(1) : DW'(i - 5);
            cyc();
            b16.port_ready = i >= 6 ? 16'hFFFF : ~16'h0020;
            b16.rd_valid = i < 3; b16.rd_port = 4'd5; b16.rd_data = DW'(i + 1);
            mid();
            checks++; if (b16.rd_ready !== exp_rr) begin errors++; $display("FAIL bp_rd_ready[%0d]: got %b want %b", i, b16.rd_ready, exp_rr); end
            checks++; if (b16.port_valid !== exp_pv) begin errors++; $display("FAIL bp_pv[%0d]: got %h want %h", i, b16.port_valid, exp_pv); end
            if (i >= 2 && i <= 8) begin
                checks++; if (b16.port_data !== exp_d) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, b16.port_data, exp_d); end
            end
        end
        b16.rd_valid = 1'b0;
        checks++; if (b16.delivered !== 4'd5) begin errors++; $display("FAIL bp_delivered: got %0d want 5", b16.delivered); end
    endtask

    task automatic test_bad_port();
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            logic exp_bad;
            logic [7:0] exp_pv;
            exp_bad = i == 1;
            exp_pv  = i == 3 ? 8'h04 : 8'h00;
            cyc();
            b8.rd_valid = i < 2; b8.rd_port = i == 0 ? 4'd12 : 4'd2; b8.rd_data = DW'('h22);
            mid();
            pulses += int'(b8.bad_port);
            checks++; if (b8.bad_port !== exp_bad) begin errors++; $display("FAIL bad_pulse[%0d]: got %b want %b", i, b8.bad_port, exp_bad); end
            checks++; if (b8.port_valid !== exp_pv) begin errors++; $display("FAIL bad_pv[%0d]: got %h want %h", i, b8.port_valid, exp_pv); end
        end
        b8.rd_valid = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bad_count: got %0d want 1", pulses); end
        checks++; if (b8.delivered !== 4'd2) begin errors++; $display("FAIL bad_delivered: got %0d want 2", b8.delivered); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 70; i++) begin
            logic exp_to;
            logic [15:0] exp_pv;
`ifdef READ_DIST_TIMEOUT_EN
            exp_to = i == 65;
            exp_pv = (i >= 2 && i <= 65) ? 16'h0080 : i == 66 ? 16'h0002 : 16'h0;
`else
            exp_to = 1'b0;
            exp_pv = i >= 2 ? 16'h0080 : 16'h0;
`endif
            cyc();
            b16.port_ready = ~16'h0080;
            b16.rd_valid = i < 2; b16.rd_port = i == 0 ? 4'd7 : 4'd1; b16.rd_data = DW'(i + 'h70);
            mid();
            checks++; if (b16.timeout_drop !== exp_to) begin errors++; $display("FAIL to_pulse[%0d]: got %b want %b", i, b16.timeout_drop, exp_to); end
            checks++; if (b16.port_valid !== exp_pv) begin errors++; $display("FAIL to_pv[%0d]: got %h want %h", i, b16.port_valid, exp_pv); end
            if (i == 66) begin
                checks++; if (b16.delivered !== 4'd5) begin errors++; $display("FAIL to_delivered_kept: got %0d want 5", b16.delivered); end
            end
        end
        b16.rd_valid = 1'b0;
        b16.port_ready = '1;
        for (int i = 0; i < 4; i++) cyc();
        mid();
        checks++; if (b16.delivered !== 4'd1) begin errors++; $display("FAIL to_drain_delivered: got %0d want 1", b16.delivered); end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 4; i++) begin
            cyc();
            b16.port_ready = ~16'h0020;
            b16.rd_valid = i < 3; b16.rd_port = 4'd5; b16.rd_data = DW'(i + 'h50);
        end
        mid();
        checks++; if (b16.rd_ready !== 1'b0 || b16.port_valid !== 16'h0020) begin errors++; $display("FAIL flush_pre: got rr=%b pv=%h want rr=0 pv=0020", b16.rd_ready, b16.port_valid); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        b16.port_ready = '1;
        mid();
        checks++; if (b16.port_valid !== 16'h0) begin errors++; $display("FAIL flush_pv: got %h want 0000", b16.port_valid); end
        checks++; if (b16.delivered !== 4'd0) begin errors++; $display("FAIL flush_delivered: got %0d want 0", b16.delivered); end
        checks++; if (b16.rd_ready !== 1'b1) begin errors++; $display("FAIL flush_rd_ready: got %b want 1", b16.rd_ready); end
        for (int i = 0; i < 4; i++) begin
            cyc(); mid();
            checks++; if (b16.port_valid !== 16'h0) begin errors++; $display("FAIL flush_stale[%0d]: got %h want 0000", i, b16.port_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_bad_port();
        test_timeout();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/read_channel_distributor.md
Name: read_channel_distributor

Overview:
- Return path of the SRAM write/read arbitration datapath: takes read-data beats tagged with a 4-bit port id from the SRAM read side and delivers each beat to the addressed client port.
- Mirror of the write-side selecter: N ports to 1 on write, 1 to N ports here.
- Buffers beats in a small FIFO, then presents each beat on a registered output stage with per-port valid/ready handshake and backpressure.

Parameters:
- num_of_ports, 16, number of client ports; must be ≤ 16, since port ids are 4 bits.
- arbiter_data_width, 256, data beat width in bits.
- fifo_depth, 2, input FIFO entries; power of two, ≥ 2.
- timeout_cycles, 64, stall limit before a beat is dropped; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rd_valid  input  1  SRAM read beat valid.
- rd_ready  output  1  block can accept a beat; equals !fifo_full.
- rd_port  input  4  destination port id of the beat.
- rd_data  input  arbiter_data_width  read data beat.
- port_valid  output  num_of_ports  one-hot valid; bit k = beat for port k.
- port_ready  input  num_of_ports  per-port accept.
- port_data  output  arbiter_data_width  shared data bus to all ports.
- delivered  output  4  id of the last port that completed a handshake.
- bad_port  output  1  one-cycle pulse: beat dropped for id ≥ num_of_ports.
- timeout_drop  output  1  one-cycle pulse: beat dropped on stall timeout (optional feature).

Behaviour:
- Reset values: all outputs 0, except rd_ready = 1 after the first post-reset cycle (FIFO empty). FIFO pointers and count are 0; state is IDLE.
- rst asserted mid-operation flushes the FIFO and the output stage. Any beat in flight is lost, with no pulse.
- Push: when rd_valid && rd_ready, {rd_port, rd_data} is written at the write pointer. The pointer wraps modulo fifo_depth.
- No push when full, even if a pop happens in the same cycle. rd_ready is registered-free but depends only on the count, not on port_ready.
- FSM, two states:
  - IDLE: output stage empty.
  - HOLD: output stage holds out_port and out_data.
- IDLE -> HOLD when the FIFO is non-empty and the head id is < num_of_ports. The head is popped into the output register.
  - If the head id is ≥ num_of_ports, pop it, pulse bad_port for 1 cycle, and stay in IDLE.
- In HOLD:
  - port_valid = 1 << out_port.
  - port_data = out_data.
  - Handshake completes when port_ready[out_port] = 1; other ready bits are ignored.
- On handshake:
  - delivered <= out_port.
  - If the FIFO is non-empty with a valid id, load the next head in the same cycle and stay in HOLD (back-to-back, 1 beat/cycle).
  - Otherwise go to IDLE.
- In IDLE, port_valid = 0 and port_data = 0.
- Latency: a beat pushed in cycle N into an empty block appears on port_valid in cycle N+2.
- Ordering: strict FIFO order across all ports. A stalled port blocks all later beats (head-of-line), unless the timeout feature is enabled.
- delivered holds its value between handshakes.

Optional Feature:
- Macro: READ_DIST_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-minimum stall counter clears on entering HOLD and on each handshake, and increments each HOLD cycle without a handshake.
  - When it reaches timeout_cycles-1 without a handshake, the beat is discarded, timeout_drop pulses for 1 cycle, delivered is unchanged, and the FSM proceeds as after a handshake (next head or IDLE).
- Without the macro: no counter; beats are held indefinitely; timeout_drop is tied to 0.

Test Plan:
- Reset then push {port 3, data 0xA5..A5}; hold port_ready = 0xFFFF -> port_valid = 0x0008 and port_data = 0xA5..A5 exactly 2 cycles after push; delivered = 3 the following cycle.
- Push ports 0, 1, 2 on consecutive cycles with all ready -> port_valid = 0x0001, 0x0002, 0x0004 on consecutive cycles; rd_ready never drops.
- Hold port_ready[5] = 0 and push to port 5 three times -> FIFO fills and rd_ready = 0; release ready -> 3 beats delivered in order and rd_ready returns to 1.
- num_of_ports = 8, push rd_port = 12 -> bad_port pulses once, no port_valid, next beat to port 2 delivered normally.
- With READ_DIST_TIMEOUT_EN and timeout_cycles = 64: port 7 never ready -> timeout_drop pulses in HOLD cycle 64; the queued beat for port 1 is delivered next cycle.
- Assert rst for 1 cycle while in HOLD with the FIFO full -> next cycle port_valid = 0, delivered = 0, rd_ready = 1; old beats never appear.
